// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential divider: FSM encoding and default widths.
package seq_divider_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/seq_divider_subtractor.sv
// Ripple adder and the subtractor built from it (B inverted, carry-in set).
module nbit_adder #(
  parameter int N = 32
) (
  output logic [N-1:0] sum,
  output logic         C_out,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_in
);
  assign {C_out, sum} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, C_in};
endmodule

module nbit_subtractor #(
  parameter int N = 32
) (
  output logic [N-1:0] diff,
  output logic         C_out,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B
);
  // C_out=1 means A>=B (no borrow)
  nbit_adder #(.N(N)) u_add (
    .sum  (diff),
    .C_out(C_out),
    .A    (A),
    .B    (~B),
    .C_in (1'b1)
  );
endmodule

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per clock, start/busy/done handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_reg_q, q_reg_d, r_reg_q, r_reg_d, div_q, div_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dbz_q, dbz_d, done_q, done_d;

  logic             msb, c_out, take;
  logic [WIDTH-1:0] r_sh, q_sh, diff, r_nxt, q_nxt;

  // msb is bit WIDTH of the shifted partial remainder; when set it always exceeds the divisor
  assign msb   = r_reg_q[WIDTH-1];
  assign r_sh  = {r_reg_q[WIDTH-2:0], q_reg_q[WIDTH-1]};
  assign q_sh  = {q_reg_q[WIDTH-2:0], 1'b0};
  assign take  = msb | c_out;
  assign r_nxt = take ? diff : r_sh;
  assign q_nxt = q_sh | {{(WIDTH-1){1'b0}}, take};

  nbit_subtractor #(.N(WIDTH)) u_sub (
    .diff (diff),
    .C_out(c_out),
    .A    (r_sh),
    .B    (div_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_reg_d = q_reg_q;
    r_reg_d = r_reg_q;
    div_d   = div_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        q_reg_d = dividend;
        r_reg_d = '0;
        div_d   = divisor;
        cnt_d   = CW'(WIDTH-1);
        if (divisor == '0) begin
          quot_d  = '1;
          rem_d   = dividend;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        q_reg_d = q_nxt;
        r_reg_d = r_nxt;
        if (cnt_q == '0) begin
          quot_d  = q_nxt;
          rem_d   = r_nxt;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_reg_q <= '0;
      r_reg_q <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_reg_q <= q_reg_d;
      r_reg_q <= r_reg_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule
